badger_rx_drain: RTL and testbench

- Hardware client of the Badger host receive interface; replaces firmware polling of the RX packet buffer.
- Polls the RX status word and reads each pending frame word-by-word through the index/strobe/data path.
- Presents each frame as a 32-bit valid/ready stream with last and byte-keep, then pulses the bank-release strobe.
- Sits in the sysClk domain, between the Badger wrapper's host RX ports and a fabric packet consumer.

---
 rtl/badger_rx_drain_if.sv | 28 ++
 rtl/badger_rx_drain.sv | 204 ++++++++++++++++++++
 tb/tb_badger_rx_drain.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/badger_rx_drain_if.sv
// badger_rx_drain_if: 32-bit frame stream carried from the RX drain to the
// fabric packet consumer.
//
// Signals:
//   m_data  [31:0] frame word, byte 0 in bits [7:0]
//   m_keep  [3:0]  valid-byte mask, contiguous from bit 0
//   m_last         final word of the frame
//   m_valid        word is presented
//   m_ready        consumer accepts
//
// Handshake: a word transfers on every rising clock edge where m_valid and
// m_ready are both 1. Once m_valid is raised, m_data/m_keep/m_last stay
// stable and m_valid stays high until that transfer; m_valid may not depend
// combinationally on m_ready.
//
// Modports: master = producer (badger_rx_drain), slave = consumer.
interface badger_rx_drain_if;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, output m_keep, output m_last,
                  output m_valid, input m_ready);
  modport slave  (input m_data, input m_keep, input m_last,
                  input m_valid, output m_ready);
endinterface

// File: rtl/badger_rx_drain.sv
// badger_rx_drain: hardware client of the Badger host RX buffer. Polls the RX
// status word, reads the pending frame word-by-word through the
// index/strobe/data path, streams it out and releases the host bank.
//
// Ports:
//   sysClk, sysReset   clock, asynchronous active-high reset
//   enable             1 = poll and drain; 0 = finish current frame, then idle
//   sysRxStatus[31:0]  host RX status, bit 0 = bank holds a frame
//   sysRxData[31:0]    buffer read data, valid two cycles after a data strobe
//   sysGPIO_OUT[31:0]  index / release command word (held between strobes)
//   sysRxDataStrobe    one-cycle pulse, loads index from sysGPIO_OUT
//   sysRxStrobe        one-cycle pulse, with sysGPIO_OUT=2 releases the bank
//   stream             frame stream (badger_rx_drain_if.master)
//   oversize           one-cycle pulse when a frame is dropped for bad length
//   fsm_state[2:0]     current controller state, for observation
//
// Optional build macro BADGER_RX_DRAIN_STATS_EN adds stats_clear (in) and
// frame_count[15:0] / drop_count[15:0] (out), saturating counters.
//
// Word 0 of the bank is the header, length in bytes in bits [LEN_MSB:0];
// payload words sit at indices 1..ceil(len/4).
module badger_rx_drain #(
  parameter int INDEX_WIDTH   = 9,
  parameter int LEN_MSB       = 10,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              sysClk,
  input  logic              sysReset,
  input  logic              enable,
  input  logic [31:0]       sysRxStatus,
  input  logic [31:0]       sysRxData,
  output logic [31:0]       sysGPIO_OUT,
  output logic              sysRxDataStrobe,
  output logic              sysRxStrobe,
  badger_rx_drain_if.master stream,
  output logic              oversize,
  output logic [2:0]        fsm_state
`ifdef BADGER_RX_DRAIN_STATS_EN
  ,
  input  logic              stats_clear,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int LW = LEN_MSB + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_HDR_WAIT = 3'd2,
    S_RD       = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_OUT      = 3'd5,
    S_RELEASE  = 3'd6,
    S_SETTLE   = 3'd7
  } state_t;

  state_t                 state, state_next;
  logic                   wait_cnt;
  logic [SW-1:0]          settle_cnt;
  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] nwords;
  logic [1:0]             len_mod;
  logic                   dropped;
  logic [31:0]            data_q;
  logic [3:0]             keep_q;
  logic                   last_q;
  logic [3:0]             last_keep;

  // Header decode, evaluated against the live read data in HDR_WAIT.
  logic [LW-1:0]          hdr_len;
  logic [LW:0]            hdr_words;
  logic                   hdr_bad;
  logic                   settle_done;
  logic                   status_unused;

  assign hdr_len     = sysRxData[LEN_MSB:0];
  assign hdr_words   = ({1'b0, hdr_len} + (LW+1)'(3)) >> 2;
  assign hdr_bad     = (hdr_len == '0) ||
                       (hdr_words > (LW+1)'((2 ** INDEX_WIDTH) - 1));
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign status_unused = ^sysRxStatus[31:1];

  always_comb begin
    case (len_mod)
      2'd1:    last_keep = 4'b0001;
      2'd2:    last_keep = 4'b0011;
      2'd3:    last_keep = 4'b0111;
      default: last_keep = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic. Each wait state lasts two cycles (wait_cnt 0 then 1),
  // so the read data is captured on the second cycle after the strobe.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (enable && sysRxStatus[0]) state_next = S_HDR;
      S_HDR:      state_next = S_HDR_WAIT;
      S_HDR_WAIT: if (wait_cnt) state_next = hdr_bad ? S_RELEASE : S_RD;
      S_RD:       state_next = S_RD_WAIT;
      S_RD_WAIT:  if (wait_cnt) state_next = S_OUT;
      S_OUT:      if (stream.m_ready) state_next = last_q ? S_RELEASE : S_RD;
      S_RELEASE:  state_next = S_SETTLE;
      S_SETTLE:   if (settle_done) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode: strobes and valid are pure functions of state.
  always_comb begin
    sysRxDataStrobe = 1'b0;
    sysRxStrobe     = 1'b0;
    stream.m_valid  = 1'b0;
    case (state)
      S_HDR, S_RD: sysRxDataStrobe = 1'b1;
      S_RELEASE:   sysRxStrobe     = 1'b1;
      S_OUT:       stream.m_valid  = 1'b1;
      default:     ;
    endcase
  end

  assign stream.m_data = data_q;
  assign stream.m_keep = keep_q;
  assign stream.m_last = last_q;
  assign fsm_state     = state;

  // Datapath. sysGPIO_OUT is loaded on the edge that enters a strobe state,
  // so the command word is already stable while the strobe is high.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      wait_cnt    <= 1'b0;
      settle_cnt  <= '0;
      idx         <= '0;
      nwords      <= '0;
      len_mod     <= '0;
      dropped     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      sysGPIO_OUT <= '0;
      oversize    <= 1'b0;
    end else begin
      wait_cnt   <= (state == S_HDR_WAIT || state == S_RD_WAIT) ? ~wait_cnt : 1'b0;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
      oversize   <= 1'b0;
      case (state)
        S_IDLE: if (state_next == S_HDR) sysGPIO_OUT <= '0;
        S_HDR_WAIT: if (wait_cnt) begin
          len_mod  <= hdr_len[1:0];
          nwords   <= hdr_words[INDEX_WIDTH-1:0];
          dropped  <= hdr_bad;
          oversize <= hdr_bad;
          if (hdr_bad) begin
            sysGPIO_OUT <= 32'h2;
          end else begin
            idx         <= INDEX_WIDTH'(1);
            sysGPIO_OUT <= 32'h1;
          end
        end
        S_RD_WAIT: if (wait_cnt) begin
          data_q <= sysRxData;
          last_q <= (idx == nwords);
          keep_q <= (idx == nwords) ? last_keep : 4'b1111;
        end
        S_OUT: if (stream.m_ready) begin
          if (last_q) begin
            sysGPIO_OUT <= 32'h2;
          end else begin
            idx         <= idx + INDEX_WIDTH'(1);
            sysGPIO_OUT <= 32'(idx + INDEX_WIDTH'(1));
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BADGER_RX_DRAIN_STATS_EN
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else if (stats_clear) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (state == S_RELEASE && !dropped && frame_count != 16'hFFFF)
        frame_count <= frame_count + 16'd1;
      if (oversize && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_badger_rx_drain.sv
module tb_badger_rx_drain;

  localparam int SETTLE = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        status_bit;
  logic [31:0] rx_status;
  logic [31:0] rx_data;
  logic [31:0] gpio;
  logic        ds, rs, ovs_pulse;
  logic [2:0]  fsm_state;
`ifdef BADGER_RX_DRAIN_STATS_EN
  logic        stats_clear = 1'b0;
  logic [15:0] frame_count, drop_count;
`endif

  always #5 clk = ~clk;

  badger_rx_drain_if stream_if ();

  assign rx_status = {31'b0, status_bit};

  badger_rx_drain dut (
    .sysClk          (clk),
    .sysReset        (rst),
    .enable          (enable),
    .sysRxStatus     (rx_status),
    .sysRxData       (rx_data),
    .sysGPIO_OUT     (gpio),
    .sysRxDataStrobe (ds),
    .sysRxStrobe     (rs),
    .stream          (stream_if),
    .oversize        (ovs_pulse),
    .fsm_state       (fsm_state)
`ifdef BADGER_RX_DRAIN_STATS_EN
    ,
    .stats_clear     (stats_clear),
    .frame_count     (frame_count),
    .drop_count      (drop_count)
`endif
  );

  // ---------------- host RX buffer model ----------------
  // Index latched on the strobe edge, read data registered one more cycle:
  // data for a strobe in cycle t is visible during cycle t+2.
  logic [31:0] mem [0:511];
  logic [8:0]  idx_q = '0;
  logic [31:0] data_q = '0;
  always @(posedge clk) begin
    if (ds) idx_q <= gpio[8:0];
    data_q <= mem[idx_q];
  end
  assign rx_data = data_q;

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];   // {last, keep, data}
  int n_vec = 0;
  int n_err = 0;

  int beats = 0, dstrobes = 0, pstrobes = 0, rstrobes = 0;
  int ovs = 0, valid_cycles = 0, overlap = 0;
  logic [31:0] last_rel_gpio = '0;
  int base_beats, base_d, base_p, base_r, base_o, base_v, base_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ds) begin
        check("strobe_index", gpio, 32'(dstrobes - base_d));
        dstrobes++;
        if (gpio != 0) pstrobes++;
      end
      if (rs) begin
        rstrobes++;
        last_rel_gpio = gpio;
      end
      if (ds && rs) overlap++;
      if (ovs_pulse) ovs++;
      if (stream_if.m_valid) valid_cycles++;
      if (stream_if.m_valid && stream_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("beat_data", stream_if.m_data, e[31:0]);
          check("beat_keep", 32'(stream_if.m_keep), 32'(e[35:32]));
          check("beat_last", 32'(stream_if.m_last), 32'(e[36]));
        end
        beats++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_keep_of(input int len);
    int r;
    r = len % 4;
    if (r == 0) return 4'hF;
    return 4'hF >> (4 - r);
  endfunction

  task automatic rebase();
    base_beats = beats; base_d = dstrobes; base_p = pstrobes; base_r = rstrobes;
    base_o = ovs; base_v = valid_cycles; base_ov = overlap;
  endtask

  // Expected beats for the frame currently in mem; len is the header length.
  task automatic build_expected(input int len);
    int n;
    exp_q.delete();
    n = (len + 3) / 4;
    if (len != 0 && n <= 511)
      for (int i = 1; i <= n; i++)
        exp_q.push_back({(i == n), (i == n) ? exp_keep_of(len) : 4'hF, mem[i]});
  endtask

  task automatic start_frame(input int len);
    int n;
    n = (len + 3) / 4;
    // Garbage above the length field must be ignored.
    mem[0] = ($urandom() & 32'hFFFF_F800) | 32'(len);
    if (n > 511) n = 511;
    for (int i = 1; i <= n; i++) mem[i] = $urandom();
    build_expected(len);
    rebase();
    status_bit = 1'b1;
  endtask

  task automatic wait_release(input int budget);
    int k;
    k = 0;
    while (rstrobes == base_r && k < budget) begin
      tick(1);
      k++;
    end
    if (rstrobes == base_r) check("release_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while ((beats - base_beats) < n && k < budget) begin
      tick(1);
      k++;
    end
    if ((beats - base_beats) < n) check("beat_timeout", 32'(beats - base_beats), 32'(n));
  endtask

  task automatic finish_frame(input int exp_beats, input int exp_ovs);
    status_bit = 1'b0;
    tick(SETTLE + 4);
    check("beats", 32'(beats - base_beats), 32'(exp_beats));
    check("payload_strobes", 32'(pstrobes - base_p), 32'(exp_beats));
    check("data_strobes", 32'(dstrobes - base_d), 32'(exp_beats + 1));
    check("release_strobes", 32'(rstrobes - base_r), 32'd1);
    check("release_gpio", last_rel_gpio, 32'h2);
    check("oversize_pulses", 32'(ovs - base_o), 32'(exp_ovs));
    check("strobe_overlap", 32'(overlap - base_ov), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("idle_after", 32'(fsm_state), 32'd0);
    if (exp_ovs != 0) check("no_valid", 32'(valid_cycles - base_v), 32'd0);
  endtask

  task automatic check_all_zero();
    check("rst_gpio", gpio, 32'h0);
    check("rst_ds", 32'(ds), 32'd0);
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_valid", 32'(stream_if.m_valid), 32'd0);
    check("rst_data", stream_if.m_data, 32'h0);
    check("rst_keep", 32'(stream_if.m_keep), 32'd0);
    check("rst_last", 32'(stream_if.m_last), 32'd0);
    check("rst_oversize", 32'(ovs_pulse), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] word1;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    rst = 1'b1; enable = 1'b0; status_bit = 1'b0; stream_if.m_ready = 1'b0;
    rebase();

    // Reset state
    tick(3);
    check_all_zero();
    rst = 1'b0;
    tick(4);
    check("idle_no_strobe", 32'(dstrobes), 32'd0);
    check("idle_state", 32'(fsm_state), 32'd0);
    enable = 1'b1;
    stream_if.m_ready = 1'b1;

    // 64-byte frame, full last word
    start_frame(64);
    wait_release(400);
    finish_frame(16, 0);

    // 61-byte frame, last keep 0001
    start_frame(61);
    wait_release(400);
    finish_frame(16, 0);

    // Zero length: dropped
    start_frame(0);
    wait_release(100);
    finish_frame(0, 1);

    // 2045 bytes -> 512 words, one beyond the bank: dropped
    start_frame(2045);
    wait_release(100);
    finish_frame(0, 1);

    // 2044 bytes -> 511 words, largest frame that streams
    start_frame(2044);
    wait_release(3000);
    finish_frame(511, 0);

    // 8-byte frame with the first beat stalled for 20 cycles
    stream_if.m_ready = 1'b0;
    start_frame(8);
    word1 = mem[1];
    begin
      int k;
      k = 0;
      while (!stream_if.m_valid && k < 50) begin tick(1); k++; end
      check("stall_valid_seen", 32'(stream_if.m_valid), 32'd1);
    end
    for (int c = 0; c < 20; c++) check("stall_data", stream_if.m_data, word1);
    tick(0);
    for (int c = 0; c < 20; c++) begin
      if (c == 19) check("stall_valid_held", 32'(stream_if.m_valid), 32'd1);
      check("stall_data_cycle", stream_if.m_data, word1);
      tick(1);
    end
    check("stall_payload_strobes", 32'(pstrobes - base_p), 32'd1);
    stream_if.m_ready = 1'b1;
    wait_release(100);
    finish_frame(2, 0);

    // enable dropped at beat 3 of 10; status stays high
    start_frame(40);
    wait_beats(3, 200);
    enable = 1'b0;
    wait_release(200);
    tick(SETTLE + 30);
    check("en_beats", 32'(beats - base_beats), 32'd10);
    check("en_data_strobes", 32'(dstrobes - base_d), 32'd11);
    check("en_release", 32'(rstrobes - base_r), 32'd1);
    check("en_idle", 32'(fsm_state), 32'd0);
    check("en_exp_q_empty", 32'(exp_q.size()), 32'd0);
    status_bit = 1'b0;
    enable = 1'b1;
    tick(2);

    // Reset at beat 5: no release, frame re-read from the header
    start_frame(40);
    wait_beats(5, 200);
    rst = 1'b1;
    #1;
    check_all_zero();
    tick(3);
    check("rst_hold_rs", 32'(rs), 32'd0);
    check("rst_no_release", 32'(rstrobes - base_r), 32'd0);
    build_expected(40);
    rebase();
    rst = 1'b0;
    wait_release(300);
    finish_frame(10, 0);

`ifdef BADGER_RX_DRAIN_STATS_EN
    check("frame_count", 32'(frame_count), 32'd1);
    check("drop_count", 32'(drop_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
